// File: rtl/mux_rr_sched_pkg.sv
// Shared definitions for the level-2 round-robin lane scheduler and its helpers.
// The lane count, the data width, the FSM state encodings and the pointer reset value live here.
package mux_rr_sched_pkg;

    localparam int NUM_LANES = 4;
    localparam int DATA_W    = 8;
    localparam int IDX_W     = 2;
    localparam int CNT_W     = 4;

    // Reset pointer sits on the last lane, so the first scan starts at lane 0.
    localparam logic [IDX_W-1:0] LAST_PTR_RST = 2'd3;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

endpackage

// File: rtl/mux_rr_sched_rr_pick.sv
// Rotating-priority encoder: picks the first valid lane after i_ptr, scanning cyclically.
// Purely combinational. When no lane is valid, o_any is low and o_idx is 0.
module rr_pick
    import mux_rr_sched_pkg::*;
(
    input  logic [NUM_LANES-1:0] i_valid,
    input  logic [IDX_W-1:0]     i_ptr,
    output logic [IDX_W-1:0]     o_idx,
    output logic                 o_any
);

    logic [IDX_W-1:0] w_cand;

    // Walk from the farthest candidate to the nearest, so the nearest valid lane wins.
    always_comb begin
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = '0;
        for (int k = NUM_LANES; k >= 1; k--) begin
            w_cand = i_ptr + IDX_W'(k);
            if (i_valid[w_cand]) begin
                o_idx = w_cand;
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler that shares one registered byte channel among four lanes, with a burst lock.
// A transfer is visible one cycle after the accepting edge; a stalled output holds and no lane is accepted.
module mux_rr_sched
    import mux_rr_sched_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] dataIn0,
    input  logic [DATA_W-1:0] dataIn1,
    input  logic [DATA_W-1:0] dataIn2,
    input  logic [DATA_W-1:0] dataIn3,
    input  logic              validIn0,
    input  logic              validIn1,
    input  logic              validIn2,
    input  logic              validIn3,
    output logic              readyOut0,
    output logic              readyOut1,
    output logic              readyOut2,
    output logic              readyOut3,
    output logic [DATA_W-1:0] dataOut,
    output logic              validOut,
    input  logic              readyIn,
    output logic [IDX_W-1:0]  grantOut
);

    localparam logic [CNT_W:0] MAX_BURST_W = (CNT_W+1)'(MAX_BURST);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_last_ptr;
    logic [IDX_W-1:0]   r_owner;
    logic [CNT_W-1:0]   r_burst_cnt;
    logic [DATA_W-1:0]  r_data;
    logic               r_valid;
    logic [IDX_W-1:0]   r_grant;

    logic [DATA_W-1:0]  w_data [NUM_LANES];
    logic [NUM_LANES-1:0] w_valid;
    logic [NUM_LANES-1:0] w_ready;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_any;
    logic [IDX_W-1:0]   w_sel;
    logic               w_sel_ok;
    logic               w_can_load;
    logic               w_xfer;
    logic [CNT_W:0]     w_cnt_inc;
    logic               w_stay_locked;

    assign w_data[0] = dataIn0;
    assign w_data[1] = dataIn1;
    assign w_data[2] = dataIn2;
    assign w_data[3] = dataIn3;
    assign w_valid   = {validIn3, validIn2, validIn1, validIn0};

    rr_pick u_rr_pick (
        .i_valid (w_valid),
        .i_ptr   (r_last_ptr),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    // The output register can take a new beat when it is empty or being drained this cycle.
    assign w_can_load    = !r_valid || readyIn;
    assign w_sel         = (r_state == ST_LOCK) ? r_owner : w_pick_idx;
    assign w_sel_ok      = (r_state == ST_LOCK) ? w_valid[r_owner] : w_pick_any;
    assign w_xfer        = w_can_load && w_sel_ok;
    assign w_cnt_inc     = {1'b0, r_burst_cnt} + (CNT_W+1)'(1);
    assign w_stay_locked = (w_cnt_inc < MAX_BURST_W);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A locked owner that goes idle gives up the grant; nobody else is served in that cycle.
    always_comb begin
        w_state_nxt = r_state;
        if (w_xfer) begin
            w_state_nxt = w_stay_locked ? ST_LOCK : ST_ARB;
        end else if (w_can_load && (r_state == ST_LOCK)) begin
            w_state_nxt = ST_ARB;
        end
    end

    always_comb begin
        w_ready = '0;
        if (!reset && w_xfer) begin
            w_ready[w_sel] = 1'b1;
        end
    end

    assign readyOut0 = w_ready[0];
    assign readyOut1 = w_ready[1];
    assign readyOut2 = w_ready[2];
    assign readyOut3 = w_ready[3];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_grant     <= '0;
            r_last_ptr  <= LAST_PTR_RST;
            r_burst_cnt <= '0;
            r_owner     <= '0;
        end else if (w_xfer) begin
            r_data     <= w_data[w_sel];
            r_valid    <= 1'b1;
            r_grant    <= w_sel;
            r_last_ptr <= w_sel;
            if (w_stay_locked) begin
                r_burst_cnt <= w_cnt_inc[CNT_W-1:0];
                r_owner     <= w_sel;
            end else begin
                r_burst_cnt <= '0;
            end
        end else if (w_can_load) begin
            r_valid <= 1'b0;
            if (r_state == ST_LOCK) begin
                r_burst_cnt <= '0;
            end
        end
    end

    assign dataOut  = r_data;
    assign validOut = r_valid;
    assign grantOut = r_grant;

endmodule

// File: tb/tb_mux_rr_sched.sv
// Directed bench for mux_rr_sched: one instance with MAX_BURST=1 and one with MAX_BURST=4 share stimulus.
module tb_mux_rr_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] d [4];
    logic [3:0] v = '0;
    logic       rdy_in = 1'b1;

    logic [3:0] ro1, ro4;
    logic [7:0] do1, do4;
    logic       vo1, vo4;
    logic [1:0] go1, go4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_rr_sched #(.MAX_BURST(1)) dut1 (
        .clk(clk), .reset(rst),
        .dataIn0(d[0]), .dataIn1(d[1]), .dataIn2(d[2]), .dataIn3(d[3]),
        .validIn0(v[0]), .validIn1(v[1]), .validIn2(v[2]), .validIn3(v[3]),
        .readyOut0(ro1[0]), .readyOut1(ro1[1]), .readyOut2(ro1[2]), .readyOut3(ro1[3]),
        .dataOut(do1), .validOut(vo1), .readyIn(rdy_in), .grantOut(go1)
    );

    mux_rr_sched #(.MAX_BURST(4)) dut4 (
        .clk(clk), .reset(rst),
        .dataIn0(d[0]), .dataIn1(d[1]), .dataIn2(d[2]), .dataIn3(d[3]),
        .validIn0(v[0]), .validIn1(v[1]), .validIn2(v[2]), .validIn3(v[3]),
        .readyOut0(ro4[0]), .readyOut1(ro4[1]), .readyOut2(ro4[2]), .readyOut3(ro4[3]),
        .dataOut(do4), .validOut(vo4), .readyIn(rdy_in), .grantOut(go4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Outputs of an edge are looked at 1ns after it.
    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        edge_step();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    task automatic default_data();
        for (int i = 0; i < 4; i++) d[i] = 8'hA0 + 8'(i);
    endtask

    logic [1:0] exp4_a [12] = '{0,0,0,0,2,2,2,2,0,0,0,0};
    logic [1:0] exp1_a [12] = '{0,2,0,2,0,2,0,2,0,2,0,2};
    logic [1:0] exp1_s [5]  = '{0,1,2,3,0};
    logic [1:0] exp4_s [5]  = '{0,0,0,0,1};

    initial begin
        default_data();

        // Reset held with every lane valid.
        edge_step();
        rst = 1'b1;
        v   = 4'hF;
        #2;
        check("rst_vo", 32'(vo4), 32'd0);
        check("rst_do", 32'(do4), 32'h00);
        check("rst_go", 32'(go4), 32'd0);
        check("rst_ro4", 32'(ro4), 32'd0);
        check("rst_ro1", 32'(ro1), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ro4", 32'(ro4), 32'b0001);

        // All lanes valid: per-beat rotation on dut1, burst of 4 on dut4.
        for (int k = 0; k < 5; k++) begin
            edge_step();
            check($sformatf("rr1_go%0d", k), 32'(go1), 32'(exp1_s[k]));
            check($sformatf("rr1_do%0d", k), 32'(do1), 32'(8'hA0 + 8'(exp1_s[k])));
            check($sformatf("rr1_vo%0d", k), 32'(vo1), 32'd1);
            check($sformatf("rr4_go%0d", k), 32'(go4), 32'(exp4_s[k]));
        end

        // Lanes 0 and 2 only.
        v = 4'b0101;
        pulse_reset();
        for (int k = 0; k < 12; k++) begin
            #1;
            check($sformatf("l02_ro13_%0d", k), 32'(ro4 & 4'b1010), 32'd0);
            edge_step();
            check($sformatf("l02_go4_%0d", k), 32'(go4), 32'(exp4_a[k]));
            check($sformatf("l02_go1_%0d", k), 32'(go1), 32'(exp1_a[k]));
        end

        // Backpressure mid-burst on lane 0, with per-beat data on lane 0.
        pulse_reset();
        d[0] = 8'h10;
        edge_step();
        check("bp_b0", 32'(do4), 32'h10);
        d[0] = 8'h11;
        edge_step();
        check("bp_b1", 32'(do4), 32'h11);
        d[0] = 8'h12;
        rdy_in = 1'b0;
        #1;
        check("bp_ro_low", 32'(ro4), 32'd0);
        for (int k = 0; k < 3; k++) begin
            edge_step();
            check($sformatf("bp_do_hold%0d", k), 32'(do4), 32'h11);
            check($sformatf("bp_go_hold%0d", k), 32'(go4), 32'd0);
            check($sformatf("bp_vo_hold%0d", k), 32'(vo4), 32'd1);
            check($sformatf("bp_ro_stall%0d", k), 32'(ro4), 32'd0);
        end
        rdy_in = 1'b1;
        #1;
        check("bp_ro_resume", 32'(ro4), 32'b0001);
        edge_step();
        check("bp_b2", 32'(do4), 32'h12);
        d[0] = 8'h13;
        edge_step();
        check("bp_b3", 32'(do4), 32'h13);
        check("bp_b3_go", 32'(go4), 32'd0);
        edge_step();
        check("bp_next_go", 32'(go4), 32'd2);
        check("bp_next_do", 32'(do4), 32'hA2);
        default_data();

        // Owner drops valid after two beats; grant moves on to lane 3.
        v = 4'b1001;
        pulse_reset();
        edge_step();
        edge_step();
        check("drop_b1_go", 32'(go4), 32'd0);
        v = 4'b1000;
        #1;
        check("drop_ro_none", 32'(ro4), 32'd0);
        edge_step();
        check("drop_bubble_vo", 32'(vo4), 32'd0);
        check("drop_bubble_go", 32'(go4), 32'd0);
        edge_step();
        check("drop_next_go", 32'(go4), 32'd3);
        check("drop_next_do", 32'(do4), 32'hA3);
        check("drop_next_vo", 32'(vo4), 32'd1);

        // Reset in the middle of a lane-2 burst.
        v = 4'b0100;
        pulse_reset();
        edge_step();
        edge_step();
        check("mid_go", 32'(go4), 32'd2);
        rst = 1'b1;
        #1;
        check("mid_rst_vo", 32'(vo4), 32'd0);
        check("mid_rst_do", 32'(do4), 32'h00);
        check("mid_rst_go", 32'(go4), 32'd0);
        v = 4'b1100;
        #1;
        rst = 1'b0;
        edge_step();
        check("mid_after_go", 32'(go4), 32'd2);
        check("mid_after_do", 32'(do4), 32'hA2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1);
    end

endmodule
